// File: rtl/tx_pkg.sv
// Shared types and line levels for the byte serializer.
// Imported by the serializer top and its bit timer.
package tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT
  } tx_state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam int   DATA_BITS_PER_FRAME = 8;

endpackage

// File: rtl/bit_timer.sv
// Flexible period counter: counts 0..rollover_val and wraps.
// rollover_flag marks the last cycle of each period.
module bit_timer #(
  parameter int CNT_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 count_enable,
  input  logic [CNT_WIDTH-1:0] rollover_val,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 rollover_flag
);

  assign rollover_flag = (count_out == rollover_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_out <= '0;
    end else if (clear) begin
      count_out <= '0;
    end else if (count_enable) begin
      if (rollover_flag) count_out <= '0;
      else               count_out <= count_out + 1'b1;
    end
  end

endmodule

// File: rtl/tx_serializer.sv
// Byte-to-serial transmit stage: start bit, 8 data bits LSB-first,
// stop bit, each held BIT_PERIOD clocks; done pulses after the stop bit.
module tx_serializer
  import tx_pkg::*;
#(
  parameter int BIT_PERIOD = 10,
  parameter int CNT_WIDTH  = 10
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       load,
  input  logic [7:0] data_in,
  output logic       serial_out,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BIT_PERIOD - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS_PER_FRAME - 1);

  tx_state_t            state;
  logic [7:0]           shift_reg;
  logic [2:0]           bit_idx;
  logic [CNT_WIDTH-1:0] period_cnt;
  logic                 tick;
  logic                 accept;

  // Counter runs only while a frame is on the line; a load restarts it.
  assign accept = (state == IDLE) && load;

  bit_timer #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (accept),
    .count_enable (state != IDLE),
    .rollover_val (LAST_CNT),
    .count_out    (period_cnt),
    .rollover_flag(tick)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      serial_out <= IDLE_LEVEL;
      busy       <= 1'b0;
      done       <= 1'b0;
      shift_reg  <= 8'h00;
      bit_idx    <= 3'd0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          serial_out <= IDLE_LEVEL;
          busy       <= 1'b0;
          if (load) begin
            shift_reg  <= data_in;
            bit_idx    <= 3'd0;
            serial_out <= START_LEVEL;
            busy       <= 1'b1;
            state      <= START_BIT;
          end
        end
        START_BIT: begin
          if (tick) begin
            serial_out <= shift_reg[0];
            bit_idx    <= 3'd0;
            state      <= DATA_BITS;
          end
        end
        DATA_BITS: begin
          if (tick) begin
            if (bit_idx == LAST_BIT) begin
              serial_out <= STOP_LEVEL;
              state      <= STOP_BIT;
            end else begin
              shift_reg  <= shift_reg >> 1;
              serial_out <= shift_reg[1];
              bit_idx    <= bit_idx + 3'd1;
            end
          end
        end
        STOP_BIT: begin
          if (tick) begin
            serial_out <= IDLE_LEVEL;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

  a_cnt_range: assert property (
    @(posedge clk) disable iff (!n_rst) period_cnt <= LAST_CNT
  );

endmodule
